// File: rtl/key_debounce_capture.sv
// Key conditioning for the host-polled buttons word: per-key synchronizer,
// debouncer, pressed-level bit and wrapping press counter, packed into 32 bits.
module key_debounce_capture #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned CNT_W           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_n_i,
    output logic [31:0]         buttons_word_o,
    output logic [NUM_KEYS-1:0] press_pulse_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LVL_W  = 4;
    localparam int unsigned DC_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE_CYCLES - 1);

    // Refuse to build configurations that cannot be packed into the word
    if (LVL_W + NUM_KEYS * CNT_W > WORD_W) begin : g_word_too_wide
        $fatal(1, "key_debounce_capture: 4 + NUM_KEYS*CNT_W exceeds 32 bits");
    end
    if (NUM_KEYS < 1 || NUM_KEYS > LVL_W) begin : g_bad_num_keys
        $fatal(1, "key_debounce_capture: NUM_KEYS must be 1..4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "key_debounce_capture: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q    [NUM_KEYS];
    logic [DC_W-1:0]        dc_q      [NUM_KEYS];
    logic [CNT_W-1:0]       pc_q      [NUM_KEYS];
    logic [NUM_KEYS-1:0]    pressed_q;
    logic [NUM_KEYS-1:0]    pulse_q;
    logic [WORD_W-1:0]      word_c;

    // Raw key synchronizer chains; idle (released) level out of reset
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                sync_q[k] <= '1;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_n_i[k]};
            end
        end
    end

    // Debounce, pressed level, press pulse and press counter update together
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pressed_q <= '0;
            pulse_q   <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                dc_q[k] <= '0;
                pc_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                pulse_q[k] <= 1'b0;
                if (~sync_q[k][SYNC_STAGES-1] == pressed_q[k]) begin
                    dc_q[k] <= '0;
                end else if (dc_q[k] == DC_MAX) begin
                    dc_q[k]      <= '0;
                    pressed_q[k] <= ~pressed_q[k];
                    if (!pressed_q[k]) begin
                        pulse_q[k] <= 1'b1;
                        pc_q[k]    <= pc_q[k] + CNT_W'(1);
                    end
                end else begin
                    dc_q[k] <= dc_q[k] + DC_W'(1);
                end
            end
        end
    end

    // Pack flop outputs into the status word; no logic between flops and pins
    always_comb begin
        word_c                 = '0;
        word_c[NUM_KEYS-1:0]   = pressed_q;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            word_c[LVL_W + k*CNT_W +: CNT_W] = pc_q[k];
        end
    end

    assign buttons_word_o = word_c;
    assign press_pulse_o  = pulse_q;

endmodule

// File: tb/tb_key_debounce_capture.sv
// Bench for key_debounce_capture: table-driven segments with hand-computed
// words, hand sequences for wrap and mid-debounce reset, and random key
// activity compared every cycle against a sliding-window reference model.
module tb_key_debounce_capture;

    localparam int unsigned NK   = 4;
    localparam int unsigned CW   = 6;
    localparam int unsigned DB   = 8;
    localparam int unsigned SS   = 2;
    localparam int unsigned HIST = SS + DB;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [NK-1:0] key_n_i = '1;
    logic [31:0]   buttons_word_o;
    logic [NK-1:0] press_pulse_o;

    key_debounce_capture #(
        .NUM_KEYS(NK), .CNT_W(CW), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .key_n_i(key_n_i),
        .buttons_word_o(buttons_word_o),
        .press_pulse_o(press_pulse_o)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_errors = 0;
    int seg_pulses = 0;
    int key_pulses [NK];

    // Reference model: raw input history, newest first
    logic [NK-1:0] hist [$];
    bit            m_pressed [NK];
    int            m_pc [NK];
    logic [NK-1:0] m_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < int'(HIST); i++) hist.push_back('1);
        for (int k = 0; k < int'(NK); k++) begin
            m_pressed[k] = 1'b0;
            m_pc[k] = 0;
        end
        m_pulse = '0;
    endfunction

    // One clock edge: a key flips when every sample in the last DB
    // synchronized samples disagrees with its accepted level.
    function automatic void model_edge(input logic [NK-1:0] keys);
        logic [NK-1:0] h;
        bit all_diff;
        hist.push_front(keys);
        while (hist.size() > HIST) void'(hist.pop_back());
        m_pulse = '0;
        for (int k = 0; k < int'(NK); k++) begin
            all_diff = 1'b1;
            for (int j = int'(SS); j < int'(HIST); j++) begin
                h = hist[j];
                if (bit'(~h[k]) == m_pressed[k]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_pressed[k] = ~m_pressed[k];
                if (m_pressed[k]) begin
                    m_pulse[k] = 1'b1;
                    m_pc[k] = (m_pc[k] + 1) % (1 << CW);
                end
            end
        end
    endfunction

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < int'(NK); k++) begin
            w[k] = m_pressed[k];
            w[4 + k*int'(CW) +: CW] = CW'(m_pc[k]);
        end
        return w;
    endfunction

    // One cycle: drive at negedge, advance model at posedge, compare after
    task automatic step(input logic [NK-1:0] keys, input bit rst);
        @(negedge clk_clk);
        key_n_i = keys;
        reset_reset_n = ~rst;
        if (rst) begin
            model_reset();
            #1;
            check("reset_word", buttons_word_o, 32'h0);
            check("reset_pulse", 32'(press_pulse_o), 32'h0);
        end
        @(posedge clk_clk);
        if (!rst) model_edge(keys);
        #1;
        check("model_word", buttons_word_o, model_word());
        check("model_pulse", 32'(press_pulse_o), 32'(m_pulse));
        seg_pulses += $countones(press_pulse_o);
        for (int k = 0; k < int'(NK); k++) key_pulses[k] += int'(press_pulse_o[k]);
    endtask

    typedef struct {
        bit            rst;
        logic [NK-1:0] keys;
        int            cycles;
        logic [31:0]   exp_word;
        int            exp_pulses;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input bit r, input logic [NK-1:0] k, input int c,
                                input logic [31:0] w, input int p);
        vec_t v;
        v.rst = r; v.keys = k; v.cycles = c; v.exp_word = w; v.exp_pulses = p;
        return v;
    endfunction

    initial begin
        logic [NK-1:0] cur;
        bit rnd_rst;
        for (int k = 0; k < int'(NK); k++) key_pulses[k] = 0;
        model_reset();

        // Idle, single press/release with exact latency, no auto-repeat
        vecs.push_back(mk(1, 4'hF, 3, 32'h0, 0));
        vecs.push_back(mk(0, 4'hF, 50, 32'h0, 0));
        vecs.push_back(mk(0, 4'hE, 9, 32'h0, 0));
        vecs.push_back(mk(0, 4'hE, 1, 32'h11, 1));
        vecs.push_back(mk(0, 4'hE, 20, 32'h11, 0));
        vecs.push_back(mk(0, 4'hF, 9, 32'h11, 0));
        vecs.push_back(mk(0, 4'hF, 1, 32'h10, 0));
        // Bounce on key 1: seven low, one high, never accepted
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 4'hD, 7, 32'h10, 0));
            vecs.push_back(mk(0, 4'hF, 1, 32'h10, 0));
        end
        vecs.push_back(mk(0, 4'hF, 10, 32'h10, 0));
        vecs.push_back(mk(0, 4'hD, 9, 32'h10, 0));
        vecs.push_back(mk(0, 4'hD, 1, 32'h412, 1));
        vecs.push_back(mk(0, 4'hD, 15, 32'h412, 0));
        vecs.push_back(mk(0, 4'hF, 10, 32'h410, 0));
        // Simultaneous press of keys 0 and 3 from a fresh reset
        vecs.push_back(mk(1, 4'hF, 2, 32'h0, 0));
        vecs.push_back(mk(0, 4'h6, 9, 32'h0, 0));
        vecs.push_back(mk(0, 4'h6, 1, 32'h0040_0019, 2));
        vecs.push_back(mk(0, 4'hF, 10, 32'h0040_0010, 0));

        foreach (vecs[i]) begin
            seg_pulses = 0;
            repeat (vecs[i].cycles) step(vecs[i].keys, vecs[i].rst);
            check($sformatf("tbl%0d_word", i), buttons_word_o, vecs[i].exp_word);
            check($sformatf("tbl%0d_pulses", i), 32'(seg_pulses), 32'(vecs[i].exp_pulses));
        end

        // Key 2 pressed 65 times: counter wraps through zero to one
        key_pulses[2] = 0;
        for (int i = 0; i < 65; i++) begin
            repeat (10) step(4'hB, 1'b0);
            repeat (10) step(4'hF, 1'b0);
        end
        check("wrap_pulses", 32'(key_pulses[2]), 32'd65);
        check("wrap_word", buttons_word_o, 32'h0041_0010);

        // Reset with key 0 held partway through debounce
        repeat (7) step(4'hE, 1'b0);
        check("pre_reset_word", buttons_word_o, 32'h0041_0010);
        repeat (3) step(4'hE, 1'b1);
        seg_pulses = 0;
        repeat (9) step(4'hE, 1'b0);
        check("post_reset_wait", buttons_word_o, 32'h0);
        step(4'hE, 1'b0);
        check("post_reset_press", buttons_word_o, 32'h11);
        check("post_reset_pulse", 32'(press_pulse_o), 32'h1);
        check("post_reset_count", 32'(seg_pulses), 32'd1);

        // Random key activity against the model
        cur = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < int'(NK); k++) begin
                if ($urandom_range(0, 11) == 0) cur[k] = ~cur[k];
            end
            rnd_rst = ($urandom_range(0, 999) == 0);
            step(cur, rnd_rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
